shared_buf_arbiter: RTL and testbench

// Shares one single-port result RAM among three switch output streams and the CPU read

---
 rtl/shared_buf_arbiter_if.sv | 35 +++
 rtl/shared_buf_arbiter.sv | 148 ++++++++++++++
 tb/tb_shared_buf_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/shared_buf_arbiter_if.sv
// Bus bundle between the per-port result generators, the CPU read port and the
// shared result RAM. The slave modport is the arbiter side.
interface shared_buf_arbiter_if #(
  parameter int DEPTH_LOG2 = 6
);
  localparam int ADDR_W = DEPTH_LOG2 + 2;

  // Stream write side
  logic [2:0]        req_valid;
  logic [2:0][7:0]   req_data;
  logic [2:0]        req_ready;

  // Avalon-MM read slave
  logic              chipselect;
  logic              read;
  logic [2:0]        address;
  logic [7:0]        readdata;
  logic              waitrequest;

  // Single-port result RAM
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  modport slave (
    input  req_valid, req_data, chipselect, read, address, ram_rdata,
    output req_ready, readdata, waitrequest, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output req_valid, req_data, chipselect, read, address, ram_rdata,
    input  req_ready, readdata, waitrequest, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/shared_buf_arbiter.sv
// Shares one single-port result RAM between three stream writers and the CPU
// read port. Each stream owns a circular DEPTH-byte region addressed as
// {port, ptr}. Writes are granted round-robin; a CPU pop owns the RAM in the
// cycle it issues its read address, which suppresses any write grant there.
module shared_buf_arbiter #(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                clk,
  input  logic                reset_n,
  shared_buf_arbiter_if.slave bus
);
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int ADDR_W = DEPTH_LOG2 + 2;
  localparam int CNT_W  = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, RD_RAM, RD_DONE} state_t;

  state_t                state_q;
  logic [1:0]            pop_port_q;
  logic [7:0]            readdata_q;
  logic [1:0]            rr_q;
  logic [DEPTH_LOG2-1:0] wrptr_q [3];
  logic [DEPTH_LOG2-1:0] rdptr_q [3];
  logic [CNT_W-1:0]      count_q [3];

  logic                  rd_req;
  logic                  is_pop_addr;
  logic [1:0]            pop_sel;
  logic [2:0]            empty;
  logic [2:0]            full;
  logic                  pop_issue;
  logic [2:0]            eligible;
  logic                  grant_vld;
  logic [1:0]            grant_port;
  logic [2:0]            idx3;
  logic [2:0]            wr_inc;
  logic [2:0]            rd_dec;
  logic [7:0]            rd_value;
  logic [1:0]            rr_d;

  // Decode the CPU request and per-port occupancy flags
  always_comb begin
    rd_req      = bus.chipselect & bus.read;
    is_pop_addr = (bus.address[2] == 1'b0) && (bus.address[1:0] != 2'd3);
    pop_sel     = is_pop_addr ? bus.address[1:0] : 2'd0;
    for (int i = 0; i < 3; i++) begin
      empty[i] = (count_q[i] == '0);
      full[i]  = (count_q[i] == CNT_W'(DEPTH));
    end
    // The RAM port is taken only in the IDLE cycle that launches a pop
    pop_issue = (state_q == IDLE) && rd_req && is_pop_addr && !empty[pop_sel];
  end

  // Round-robin write arbiter: first eligible port at or after rr_q
  always_comb begin
    eligible   = bus.req_valid & ~full;
    grant_vld  = 1'b0;
    grant_port = 2'd0;
    idx3       = 3'd0;
    if (!pop_issue) begin
      for (int k = 0; k < 3; k++) begin
        idx3 = {1'b0, rr_q} + 3'(k);
        if (idx3 >= 3'd3) idx3 = idx3 - 3'd3;
        if (!grant_vld && eligible[idx3[1:0]]) begin
          grant_vld  = 1'b1;
          grant_port = idx3[1:0];
        end
      end
    end
    wr_inc = grant_vld ? (3'b001 << grant_port) : 3'b000;
    rd_dec = (state_q == RD_RAM) ? (3'b001 << pop_port_q) : 3'b000;
    rr_d   = (grant_port == 2'd2) ? 2'd0 : grant_port + 2'd1;
  end

  // Register-map value returned by any non-pop access (and by a pop of an empty stream)
  always_comb begin
    case (bus.address)
      3'd3:    rd_value = 8'd252;
      3'd4:    rd_value = 8'(count_q[0]);
      3'd5:    rd_value = 8'(count_q[1]);
      3'd6:    rd_value = 8'(count_q[2]);
      3'd7:    rd_value = {2'b00, full, empty};
      default: rd_value = 8'hFF;
    endcase
  end

  // Drive the RAM and handshake outputs; write strobes are held low during reset
  always_comb begin
    bus.req_ready   = reset_n ? wr_inc : 3'b000;
    bus.ram_we      = reset_n & grant_vld;
    bus.ram_wdata   = bus.req_data[grant_port];
    bus.ram_addr    = pop_issue ? {pop_sel, rdptr_q[pop_sel]}
                                : {grant_port, wrptr_q[grant_port]};
    bus.readdata    = readdata_q;
    bus.waitrequest = rd_req && (state_q != RD_DONE);
  end

  // Read FSM: launch pop or register lookup, capture RAM data, then release the bus
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pop_port_q <= 2'd0;
      readdata_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd_req) begin
            if (pop_issue) begin
              pop_port_q <= pop_sel;
              state_q    <= RD_RAM;
            end else begin
              readdata_q <= rd_value;
              state_q    <= RD_DONE;
            end
          end
        end
        RD_RAM: begin
          // Completes even if the master dropped read; the byte is then discarded
          readdata_q <= bus.ram_rdata;
          state_q    <= RD_DONE;
        end
        RD_DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pointer, occupancy and round-robin bookkeeping; a write and a pop completion
  // on the same port leave the count unchanged while both pointers advance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_q <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        wrptr_q[i] <= '0;
        rdptr_q[i] <= '0;
        count_q[i] <= '0;
      end
    end else begin
      if (grant_vld) rr_q <= rr_d;
      for (int i = 0; i < 3; i++) begin
        if (wr_inc[i]) wrptr_q[i] <= wrptr_q[i] + 1'b1;
        if (rd_dec[i]) rdptr_q[i] <= rdptr_q[i] + 1'b1;
        if (wr_inc[i] && !rd_dec[i]) count_q[i] <= count_q[i] + 1'b1;
        else if (!wr_inc[i] && rd_dec[i]) count_q[i] <= count_q[i] - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_shared_buf_arbiter.sv
// Bench for shared_buf_arbiter: directed scenarios followed by a randomized run,
// all checked against a queue-based model of the three stream buffers.
module tb_shared_buf_arbiter;
  localparam int DL    = 6;
  localparam int DEPTH = 1 << DL;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  shared_buf_arbiter_if #(.DEPTH_LOG2(DL)) bus ();

  shared_buf_arbiter #(.DEPTH_LOG2(DL)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  // Behavioural single-port RAM with one cycle read latency
  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  // Reference model: one FIFO per stream, round-robin pointer, write totals
  logic [7:0] q [3][$];
  int         rr;
  int         wcnt [3];
  logic [7:0] exp_pop;
  bit         rand_mode;
  int         tests;
  int         fails;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_streams();
    if (rand_mode) begin
      bus.req_valid = 3'($urandom_range(0, 7));
      for (int p = 0; p < 3; p++) bus.req_data[p] = 8'($urandom);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 3; p++) begin
      q[p].delete();
      wcnt[p] = 0;
    end
    rr = 0;
  endtask

  // One clock: check the grant the model expects, then advance the model.
  // busy: a pop is launched this cycle. popp: port whose pop completes (-1 none).
  task automatic tick(input bit busy, input int popp);
    int         g;
    logic [7:0] wd;
    #1;
    g = -1;
    if (!busy) begin
      for (int k = 0; k < 3; k++) begin
        int p;
        p = (rr + k) % 3;
        if (g < 0 && bus.req_valid[p] && q[p].size() < DEPTH) g = p;
      end
    end
    chk("req_ready", {29'd0, bus.req_ready}, (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("ram_we", {31'd0, bus.ram_we}, (g >= 0) ? 32'd1 : 32'd0);
    wd = 8'd0;
    if (g >= 0) begin
      wd = bus.req_data[g];
      chk("ram_wdata", {24'd0, bus.ram_wdata}, {24'd0, wd});
      chk("ram_addr", {24'd0, bus.ram_addr}, 32'(g * DEPTH + (wcnt[g] % DEPTH)));
    end
    @(posedge clk);
    if (popp >= 0) exp_pop = q[popp].pop_front();
    if (g >= 0) begin
      q[g].push_back(wd);
      rr = (g + 1) % 3;
      wcnt[g]++;
    end
    @(negedge clk);
    drive_streams();
  endtask

  function automatic logic [7:0] status_model();
    logic [7:0] s;
    s = 8'd0;
    for (int p = 0; p < 3; p++) begin
      s[p]     = (q[p].size() == 0);
      s[p + 3] = (q[p].size() == DEPTH);
    end
    return s;
  endfunction

  // Full Avalon read: wait states checked cycle by cycle, result checked in the release cycle
  task automatic cpu_read(input logic [2:0] a, output logic [7:0] d);
    logic [7:0] ev;
    bit         issue;
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = a;
    issue = (a < 3) && (q[a].size() > 0);
    case (a)
      3'd0, 3'd1, 3'd2: ev = 8'd255;
      3'd3:             ev = 8'd252;
      3'd7:             ev = status_model();
      default:          ev = 8'(q[a - 4].size());
    endcase
    #1 chk("waitrequest_first", {31'd0, bus.waitrequest}, 32'd1);
    tick(issue, -1);
    if (issue) begin
      #1 chk("waitrequest_ram", {31'd0, bus.waitrequest}, 32'd1);
      tick(1'b0, int'(a));
      ev = exp_pop;
    end
    #1 chk("waitrequest_done", {31'd0, bus.waitrequest}, 32'd0);
    chk($sformatf("readdata_a%0d", a), {24'd0, bus.readdata}, {24'd0, ev});
    d = bus.readdata;
    tick(1'b0, -1);
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    tests = 0;
    fails = 0;
    rand_mode = 1'b0;
    model_reset();
    reset_n        = 1'b0;
    bus.req_valid  = 3'b111;
    bus.req_data   = {8'hC1, 8'hB1, 8'hA1};
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.address    = 3'd0;

    // Reset state: strobes low even with requests pending
    #2;
    chk("rst_req_ready", {29'd0, bus.req_ready}, 32'd0);
    chk("rst_ram_we", {31'd0, bus.ram_we}, 32'd0);
    chk("rst_readdata", {24'd0, bus.readdata}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n       = 1'b1;
    bus.req_valid = 3'b000;

    // 1: stream0 writes three bytes, then three pops return them in order
    bus.req_valid = 3'b001;
    bus.req_data[0] = 8'h11; tick(1'b0, -1);
    bus.req_data[0] = 8'h22; tick(1'b0, -1);
    bus.req_data[0] = 8'h33; tick(1'b0, -1);
    bus.req_valid = 3'b000;
    cpu_read(3'd0, d); chk("t1_pop0", {24'd0, d}, 32'h11);
    cpu_read(3'd0, d); chk("t1_pop1", {24'd0, d}, 32'h22);
    cpu_read(3'd0, d); chk("t1_pop2", {24'd0, d}, 32'h33);
    cpu_read(3'd4, d); chk("t1_count0", {24'd0, d}, 32'd0);

    // 2: all three streams request every cycle
    bus.req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      for (int p = 0; p < 3; p++) bus.req_data[p] = 8'(16 * p + c);
      tick(1'b0, -1);
    end
    bus.req_valid = 3'b000;
    cpu_read(3'd4, d); chk("t2_count0", {24'd0, d}, 32'd2);
    cpu_read(3'd5, d); chk("t2_count1", {24'd0, d}, 32'd2);
    cpu_read(3'd6, d); chk("t2_count2", {24'd0, d}, 32'd2);
    for (int p = 0; p < 3; p++) repeat (2) cpu_read(3'(p), d);

    // 3: fill stream1, observe back-pressure, free one entry
    bus.req_valid = 3'b010;
    for (int c = 0; c < DEPTH; c++) begin
      bus.req_data[1] = 8'(c + 8'h40);
      tick(1'b0, -1);
    end
    #1 chk("t3_full_ready", {29'd0, bus.req_ready}, 32'd0);
    cpu_read(3'd7, d); chk("t3_status", {24'd0, d}, 32'h15);
    bus.req_data[1] = 8'hEE;
    cpu_read(3'd1, d); chk("t3_pop_first", {24'd0, d}, 32'h40);
    tick(1'b0, -1);
    bus.req_valid = 3'b000;
    while (q[1].size() > 0) cpu_read(3'd1, d);

    // 4: empty pop and constant register leave state untouched
    cpu_read(3'd2, d); chk("t4_empty_pop", {24'd0, d}, 32'd255);
    cpu_read(3'd3, d); chk("t4_const", {24'd0, d}, 32'd252);
    cpu_read(3'd6, d); chk("t4_count2", {24'd0, d}, 32'd0);
    cpu_read(3'd7, d); chk("t4_status", {24'd0, d}, 32'h07);

    // 5: stream2 keeps writing while pops run on the same stream
    bus.req_valid   = 3'b100;
    bus.req_data[2] = 8'h5A;
    tick(1'b0, -1);
    tick(1'b0, -1);
    for (int c = 0; c < 4; c++) begin
      bus.req_data[2] = 8'(8'h60 + c);
      cpu_read(3'd2, d);
    end
    bus.req_valid = 3'b000;
    cpu_read(3'd6, d);

    // Read dropped while the RAM read is in flight: pop still consumes the byte
    bus.req_valid   = 3'b001;
    bus.req_data[0] = 8'h77;
    tick(1'b0, -1);
    bus.req_valid  = 3'b000;
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = 3'd0;
    tick(1'b1, -1);
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    tick(1'b0, 0);
    tick(1'b0, -1);
    cpu_read(3'd4, d); chk("drop_count0", {24'd0, d}, 32'd0);

    // Reset asserted in the middle of a pop clears everything
    bus.req_valid   = 3'b011;
    bus.req_data[0] = 8'h81;
    bus.req_data[1] = 8'h82;
    tick(1'b0, -1);
    tick(1'b0, -1);
    bus.req_valid  = 3'b000;
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = 3'd0;
    tick(1'b1, -1);
    reset_n = 1'b0;
    #1;
    chk("midrst_readdata", {24'd0, bus.readdata}, 32'd0);
    chk("midrst_ram_we", {31'd0, bus.ram_we}, 32'd0);
    model_reset();
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cpu_read(3'd7, d); chk("midrst_status", {24'd0, d}, 32'h07);
    cpu_read(3'd5, d); chk("midrst_count1", {24'd0, d}, 32'd0);

    // 6: randomized traffic; pointers wrap many times per stream
    rand_mode = 1'b1;
    drive_streams();
    for (int n = 0; n < 600; n++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 7) cpu_read(3'(op % 3), d);
      else        cpu_read(3'($urandom_range(4, 7)), d);
    end
    rand_mode     = 1'b0;
    bus.req_valid = 3'b000;
    for (int p = 0; p < 3; p++) begin
      while (q[p].size() > 0) cpu_read(3'(p), d);
    end
    cpu_read(3'd7, d); chk("final_status", {24'd0, d}, 32'h07);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
